// File: rtl/srrc_tx_interp_flt.sv
// 4x interpolating square-root raised-cosine transmit filter, 44-tap prototype in 4-phase polyphase form.
// Define SRRC_TX_SAT_EN to saturate the 22-bit sum to 18 bits; otherwise the output wraps.
module srrc_tx_interp_flt #(
    parameter logic signed [17:0] COEF [0:43] = '{
        -18'sd155,  -18'sd260,  -18'sd197,   18'sd102,   18'sd520,
         18'sd795,   18'sd618,  -18'sd120,  -18'sd1180, -18'sd1932,
        -18'sd1660,  18'sd152,  -18'sd2860, -18'sd4890, -18'sd4512,
        -18'sd820,   18'sd3120,  18'sd12450, 18'sd24780, 18'sd35920,
         18'sd40210,
         18'sd35920, 18'sd24780, 18'sd12450, 18'sd3120, -18'sd820,
        -18'sd4512, -18'sd4890, -18'sd2860,  18'sd152,  -18'sd1660,
        -18'sd1932, -18'sd1180, -18'sd120,   18'sd618,   18'sd795,
         18'sd520,   18'sd102,  -18'sd197,  -18'sd260,  -18'sd155,
         18'sd0,     18'sd0,     18'sd0
    }
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sam_clk_en,
    input  logic               sym_clk_en,
    input  logic signed [17:0] in,
    output logic signed [17:0] out
);

    logic signed [17:0] x_q    [0:10];
    logic signed [17:0] x_d    [0:10];
    logic signed [17:0] prod_q [0:10];
    logic signed [17:0] prod_d [0:10];
    logic [1:0]         p_q, p_d;
    logic signed [21:0] sum_q, sum_d;
    logic signed [17:0] out_q, out_d;
    logic signed [17:0] sum_reduced;
    logic [5:0]         tap_idx;
    logic               shift_en;

    // A symbol strobe only counts when it lands on a sample strobe.
    assign shift_en = sym_clk_en & sam_clk_en;

    always_comb begin
        x_d = x_q;
        p_d = p_q;
        if (shift_en) begin
            x_d[0] = in;
            for (int j = 1; j < 11; j++) begin
                x_d[j] = x_q[j-1];
            end
            p_d = 2'd0;
        end else if (sam_clk_en) begin
            p_d = p_q + 2'd1;
        end
    end

    // Tap 4*j+p keeps product bits [34:17] of x[j] times the phase coefficient.
    always_comb begin
        tap_idx = '0;
        for (int j = 0; j < 11; j++) begin
            tap_idx   = {4'(j), p_q};
            prod_d[j] = 18'((36'(x_q[j]) * 36'(COEF[tap_idx])) >>> 17);
        end
    end

    always_comb begin
        sum_d = '0;
        for (int j = 0; j < 11; j++) begin
            sum_d = sum_d + 22'(prod_q[j]);
        end
    end

`ifdef SRRC_TX_SAT_EN
    always_comb begin
        if (sum_q >= 22'sd131071) begin
            sum_reduced = 18'sh1FFFF;
        end else if (sum_q <= -22'sd131072) begin
            sum_reduced = 18'sh20000;
        end else begin
            sum_reduced = sum_q[17:0];
        end
    end
`else
    logic sum_hi_unused;
    assign sum_hi_unused = ^sum_q[21:18];
    assign sum_reduced   = sum_q[17:0];
`endif

    assign out_d = sam_clk_en ? sum_reduced : out_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < 11; j++) begin
                x_q[j]    <= '0;
                prod_q[j] <= '0;
            end
            p_q   <= '0;
            sum_q <= '0;
            out_q <= '0;
        end else begin
            x_q    <= x_d;
            prod_q <= prod_d;
            p_q    <= p_d;
            sum_q  <= sum_d;
            out_q  <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_srrc_tx_interp_flt.sv
// Scoreboard bench for srrc_tx_interp_flt: reference model of the polyphase sum feeds expected-output queues.
// Runs a shipping-coefficient instance and an all-0x10000 instance for the overflow behaviour.
module tb_srrc_tx_interp_flt;

    localparam logic signed [17:0] SAT_COEF [0:43] = '{default: 18'sh10000};

    int coef_ref [0:43] = '{
        -155, -260, -197, 102, 520, 795, 618, -120, -1180, -1932,
        -1660, 152, -2860, -4890, -4512, -820, 3120, 12450, 24780, 35920,
        40210,
        35920, 24780, 12450, 3120, -820, -4512, -4890, -2860, 152, -1660,
        -1932, -1180, -120, 618, 795, 520, 102, -197, -260, -155,
        0, 0, 0
    };

`ifdef SRRC_TX_SAT_EN
    localparam logic signed [17:0] EXP_POS = 18'sh1FFFF;
    localparam logic signed [17:0] EXP_NEG = 18'sh20000;
`else
    localparam logic signed [17:0] EXP_POS = 18'sh2FFF5;
    localparam logic signed [17:0] EXP_NEG = 18'sh10000;
`endif

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               sam_clk_en = 1'b0;
    logic               sym_clk_en = 1'b0;
    logic signed [17:0] sym_in = '0;
    logic signed [17:0] out_dut, out_sat;

    int                 n_checks = 0;
    int                 n_fail = 0;
    int                 hist [0:10];
    int                 model_phase = 0;
    logic signed [17:0] exp_q [$];
    logic signed [17:0] exp_sat_q [$];
    logic signed [17:0] last_exp = '0;
    logic signed [17:0] last_exp_sat = '0;
    bit                 strobe_seen;
    int                 exp_imp;

    srrc_tx_interp_flt dut (
        .clk(clk), .reset(reset), .sam_clk_en(sam_clk_en), .sym_clk_en(sym_clk_en),
        .in(sym_in), .out(out_dut)
    );

    srrc_tx_interp_flt #(.COEF(SAT_COEF)) dut_sat (
        .clk(clk), .reset(reset), .sam_clk_en(sam_clk_en), .sym_clk_en(sym_clk_en),
        .in(sym_in), .out(out_sat)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic signed [17:0] actual,
                                input logic signed [17:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // y = sum over the 11 symbols of the truncated product with tap 4*j+phase, then reduced to 18 bits.
    function automatic logic signed [17:0] model_out(input bit flat);
        longint             acc = 0;
        longint             c;
        longint             prod;
        logic signed [17:0] term;
        for (int j = 0; j < 11; j++) begin
            c    = flat ? 64'sd65536 : longint'(coef_ref[4*j + model_phase]);
            prod = longint'(hist[j]) * c;
            term = 18'(prod >>> 17);
            acc  = acc + longint'(term);
        end
`ifdef SRRC_TX_SAT_EN
        if (acc >= 131071) return 18'sh1FFFF;
        if (acc <= -131072) return 18'sh20000;
`endif
        return 18'(acc);
    endfunction

    task automatic apply_stimulus(input bit sam, input bit sym, input logic signed [17:0] din);
        @(negedge clk);
        sam_clk_en = sam;
        sym_clk_en = sym;
        sym_in     = din;
        if (sam) begin
            exp_q.push_back(model_out(1'b0));
            exp_sat_q.push_back(model_out(1'b1));
            if (sym) begin
                for (int j = 10; j > 0; j--) hist[j] = hist[j-1];
                hist[0]     = int'(din);
                model_phase = 0;
            end else begin
                model_phase = (model_phase + 1) % 4;
            end
        end
    endtask

    task automatic send_symbol(input logic signed [17:0] din, input bit drop_sym, input bit spurious);
        int gap;
        for (int s = 0; s < 4; s++) begin
            apply_stimulus(1'b1, (s == 0) && !drop_sym, din);
            gap = $urandom_range(3, 5);
            for (int g = 0; g < gap; g++) begin
                apply_stimulus(1'b0, spurious && (g == 1), 18'($urandom));
            end
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset      = 1'b1;
        sam_clk_en = 1'b0;
        sym_clk_en = 1'b0;
        #1;
        check_output("reset_immediate", out_dut, 18'sh0);
        check_output("reset_immediate_sat", out_sat, 18'sh0);
        for (int j = 0; j < 11; j++) hist[j] = 0;
        model_phase = 0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: a sample strobe means a new output is due; between strobes the output must hold.
    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                last_exp     = '0;
                last_exp_sat = '0;
            end else begin
                strobe_seen = sam_clk_en;
                #1;
                if (strobe_seen) begin
                    if (exp_q.size() == 0 || exp_sat_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("[TB] FAIL scoreboard_underflow: got output with no expectation queued at %0t", $time);
                    end else begin
                        last_exp     = exp_q.pop_front();
                        last_exp_sat = exp_sat_q.pop_front();
                    end
                end
                check_output(strobe_seen ? "sample" : "hold", out_dut, last_exp);
                check_output(strobe_seen ? "sample_sat" : "hold_sat", out_sat, last_exp_sat);
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int j = 0; j < 11; j++) hist[j] = 0;
        #12;
        check_output("reset_state", out_dut, 18'sh0);
        check_output("reset_state_sat", out_sat, 18'sh0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] impulse response");
        for (int i = 0; i < 49; i++) begin
            apply_stimulus(1'b1, (i % 4) == 0, (i == 0) ? 18'sh10000 : 18'sh0);
            @(posedge clk);
            #1;
            exp_imp = (i >= 1 && i <= 44) ? (coef_ref[i-1] >>> 1) : 0;
            check_output("impulse", out_dut, 18'(exp_imp));
            for (int g = 0; g < 3; g++) apply_stimulus(1'b0, 1'b0, 18'sh0);
        end

        $display("[TB] reset during impulse response");
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1'b1, (i % 4) == 0, (i == 0) ? 18'sh10000 : 18'sh0);
            for (int g = 0; g < 3; g++) apply_stimulus(1'b0, 1'b0, 18'sh0);
        end
        pulse_reset();
        for (int n = 0; n < 6; n++) send_symbol(18'sh0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_output("post_reset_zero", out_dut, 18'sh0);

        $display("[TB] random symbols with dropped and spurious strobes");
        for (int n = 0; n < 60; n++) begin
            send_symbol(18'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0);
        end
        send_symbol(18'($urandom), 1'b1, 1'b0);
        send_symbol(18'($urandom), 1'b0, 1'b1);
        send_symbol(18'($urandom), 1'b0, 1'b0);

        $display("[TB] overflow with flat coefficients");
        pulse_reset();
        for (int n = 0; n < 14; n++) send_symbol(18'sh1FFFF, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_output("overflow_pos", out_sat, EXP_POS);
        for (int n = 0; n < 14; n++) send_symbol(18'sh20000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_output("overflow_neg", out_sat, EXP_NEG);

        for (int g = 0; g < 8; g++) apply_stimulus(1'b0, 1'b0, 18'sh0);
        n_checks++;
        if (exp_q.size() != 0 || exp_sat_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL queue_drained: got %0d/%0d pending, expected 0/0",
                     exp_q.size(), exp_sat_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
